xbar_alloc: RTL

Connection allocator and configuration controller for the 4x4 three-stage crossbar (`crbar4x4`, built from six `crbar2x2` switches). It sits between the four router input ports and the crossbar `sel0` bus:
- accepts one destination request per input;
- performs per-output round-robin arbitration;
- computes the six switch settings that realise the granted permutation;
- holds that configuration stable until every granted connection signals its tail.

---
 rtl/noc_xbar_pkg.sv | 15 +
 rtl/xbar_route_calc.sv | 33 +++
 rtl/xbar_alloc.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/noc_xbar_pkg.sv
// rtl/noc_xbar_pkg.sv - shared constants, port id type and allocator state enum
package noc_xbar_pkg;

  localparam int NPORTS = 4;
  localparam int NSEL   = 6;

  typedef logic [1:0] port_id_t;

  typedef enum logic [1:0] {
    XA_IDLE = 2'd0,
    XA_CFG  = 2'd1,
    XA_XFER = 2'd2
  } xa_state_t;

endpackage

// File: rtl/xbar_route_calc.sv
// rtl/xbar_route_calc.sv - maps a complete 4-port permutation to the six 2x2 switch selects
module xbar_route_calc
  import noc_xbar_pkg::*;
(
  input  port_id_t [NPORTS-1:0] perm,
  output logic     [NSEL-1:0]   sel0
);

  logic     g0, g1, g2;
  logic     swap23;
  port_id_t upper_b;
  logic     unused_bits;

  assign g0 = perm[0][1];
  assign g1 = perm[1][1];
  assign g2 = perm[2][1];

  // Input 2 must move to the lower middle switch when it shares input 0's output group.
  assign swap23  = (g0 != g1) & (g2 == g0);
  assign upper_b = swap23 ? perm[3] : perm[2];

  assign sel0 = {
    g0 ? perm[0][0] : upper_b[0],
    g1,
    swap23,
    g0 ? upper_b[0] : perm[0][0],
    g0,
    1'b0
  };

  assign unused_bits = ^{perm[1][0], upper_b[1]};

endmodule

// File: rtl/xbar_alloc.sv
// rtl/xbar_alloc.sv - 4x4 crossbar connection allocator; optional watchdog under XBAR_ALLOC_TIMEOUT_EN
module xbar_alloc
  import noc_xbar_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] req,
  input  logic [7:0]        dst,
  input  logic [NPORTS-1:0] tail,
  output logic [NPORTS-1:0] gnt,
  output logic [NSEL-1:0]   sel0,
  output logic              cfg_vld,
  output logic              timeout
);

  xa_state_t state, state_nx;

  port_id_t [NPORTS-1:0] dst_v;
  port_id_t [NPORTS-1:0] dst_r;
  port_id_t [NPORTS-1:0] rr_ptr, rr_ptr_nx;
  port_id_t [NPORTS-1:0] win_idx;
  port_id_t [NPORTS-1:0] perm;
  port_id_t              cand;
  logic     [NPORTS-1:0] hit;
  logic     [NPORTS-1:0] win;
  logic     [NPORTS-1:0] gnt_r, gnt_nx;
  logic     [NPORTS-1:0] taken;
  logic                  assigned;
  logic     [NSEL-1:0]   sel0_r, sel0_calc;
  logic                  wd_fire;

  assign dst_v = dst;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // Per-output round robin: scanning k downward leaves the first candidate at or after rr_ptr.
  always_comb begin
    hit       = '0;
    win_idx   = '0;
    cand      = '0;
    win       = '0;
    rr_ptr_nx = rr_ptr;
    for (int o = 0; o < NPORTS; o++) begin
      for (int k = NPORTS - 1; k >= 0; k--) begin
        cand = rr_ptr[o] + port_id_t'(k);
        if (req[cand] && (dst_v[cand] == port_id_t'(o))) begin
          hit[o]     = 1'b1;
          win_idx[o] = cand;
        end
      end
      if (hit[o]) begin
        win[win_idx[o]] = 1'b1;
        rr_ptr_nx[o]    = win_idx[o] + 2'd1;
      end
    end
  end

  // Complete the permutation: idle inputs take the remaining outputs in ascending order.
  always_comb begin
    perm     = '0;
    taken    = '0;
    assigned = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (gnt_r[i]) begin
        perm[i]           = dst_r[i];
        taken[dst_r[i]]   = 1'b1;
      end
    end
    for (int i = 0; i < NPORTS; i++) begin
      if (!gnt_r[i]) begin
        assigned = 1'b0;
        for (int o = 0; o < NPORTS; o++) begin
          if (!taken[o] && !assigned) begin
            perm[i]  = port_id_t'(o);
            taken[o] = 1'b1;
            assigned = 1'b1;
          end
        end
      end
    end
  end

  xbar_route_calc u_route (
    .perm (perm),
    .sel0 (sel0_calc)
  );

`ifdef XBAR_ALLOC_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt;
  logic            wd_last;
  logic            timeout_r;

  assign wd_last = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= wd_fire;
      if (state == XA_CFG) begin
        wd_cnt <= '0;
      end else if (state == XA_XFER) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt_r;
    wd_fire  = 1'b0;
    case (state)
      XA_IDLE: begin
        if (req != '0) begin
          gnt_nx   = win;
          state_nx = XA_CFG;
        end
      end
      XA_CFG: begin
        state_nx = XA_XFER;
      end
      XA_XFER: begin
        gnt_nx = gnt_r & ~tail;
        if (gnt_nx == '0) begin
          state_nx = XA_IDLE;
        end
`ifdef XBAR_ALLOC_TIMEOUT_EN
        else if (wd_last) begin
          wd_fire  = 1'b1;
          gnt_nx   = '0;
          state_nx = XA_IDLE;
        end
`endif
      end
      default: begin
        gnt_nx   = '0;
        state_nx = XA_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= XA_IDLE;
      gnt_r  <= '0;
      rr_ptr <= '0;
      dst_r  <= '0;
      sel0_r <= '0;
    end else begin
      state <= state_nx;
      gnt_r <= gnt_nx;
      if ((state == XA_IDLE) && (req != '0)) begin
        rr_ptr <= rr_ptr_nx;
        dst_r  <= dst_v;
      end
      if (state == XA_CFG) begin
        sel0_r <= sel0_calc;
      end
    end
  end

  assign gnt     = (state == XA_XFER) ? gnt_r : '0;
  assign cfg_vld = (state == XA_XFER);
  assign sel0    = sel0_r;

endmodule
